// File: rtl/seg8_pkg.sv
// Shared constants and helpers for the multiplexed 4-digit 8-segment display path.
// Glyph codes use bit0..6 = segments a..g; bit7 is the decimal point.
package seg8_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DATA_W     = 20;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
    localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
    localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
    localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
    localparam logic [6:0] SEG_GLYPH_A = 7'h77;
    localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
    localparam logic [6:0] SEG_GLYPH_C = 7'h39;
    localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
    localparam logic [6:0] SEG_GLYPH_E = 7'h79;
    localparam logic [6:0] SEG_GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        SEL_BLANK   = 2'd0,
        SEL_VALID   = 2'd1,
        SEL_INVALID = 2'd2
    } sel_class_e;

    function automatic sel_class_e classify_sel(input logic [NUM_DIGITS-1:0] sel);
        int n;
        n = 0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            n = n + int'(sel[k]);
        end
        if (n == 0) begin
            return SEL_BLANK;
        end else if (n == 1) begin
            return SEL_VALID;
        end
        return SEL_INVALID;
    endfunction

    // Only meaningful when sel is one-hot.
    function automatic logic [1:0] onehot_index(input logic [NUM_DIGITS-1:0] sel);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel[k]) begin
                idx = 2'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment glyph to hex nibble decoder; anything outside the
// sixteen hex glyphs (including blank) reports valid_o = 0 and nibble 0.
module seg7_to_hex
    import seg8_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       valid_o
);

    always_comb begin
        nibble_o = 4'h0;
        valid_o  = 1'b1;
        case (seg_i)
            SEG_GLYPH_0: nibble_o = 4'h0;
            SEG_GLYPH_1: nibble_o = 4'h1;
            SEG_GLYPH_2: nibble_o = 4'h2;
            SEG_GLYPH_3: nibble_o = 4'h3;
            SEG_GLYPH_4: nibble_o = 4'h4;
            SEG_GLYPH_5: nibble_o = 4'h5;
            SEG_GLYPH_6: nibble_o = 4'h6;
            SEG_GLYPH_7: nibble_o = 4'h7;
            SEG_GLYPH_8: nibble_o = 4'h8;
            SEG_GLYPH_9: nibble_o = 4'h9;
            SEG_GLYPH_A: nibble_o = 4'hA;
            SEG_GLYPH_B: nibble_o = 4'hB;
            SEG_GLYPH_C: nibble_o = 4'hC;
            SEG_GLYPH_D: nibble_o = 4'hD;
            SEG_GLYPH_E: nibble_o = 4'hE;
            SEG_GLYPH_F: nibble_o = 4'hF;
            default: begin
                nibble_o = 4'h0;
                valid_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg8_scan_capture.sv
// Captures a time-multiplexed 4-digit 8-segment bus: debounces each digit dwell,
// decodes glyphs to nibbles and strobes out one 20-bit word per complete frame.
module seg8_scan_capture
    import seg8_pkg::*;
#(
    parameter int STABLE_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES   = 1048576,
    parameter bit DRAIN_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b0
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic [NUM_DIGITS-1:0] i_Drains,
    input  logic [7:0]            i_Leds,
    output logic [DATA_W-1:0]     o_Data,
    output logic                  o_Data_DV,
    output logic                  o_Frame_Err,
    output logic                  o_Timeout,
    output logic [NUM_DIGITS-1:0] o_Digit_Mask
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TOUT_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [STAB_W-1:0] STAB_MAX    = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_ACCEPT = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST   = TOUT_W'(TIMEOUT_CYCLES - 1);

    // Input synchronizers
    logic [NUM_DIGITS-1:0] drains_s1_q, drains_s2_q;
    logic [7:0]            leds_s1_q, leds_s2_q;

    // Dwell tracking
    logic [NUM_DIGITS+7:0] prev_q;
    logic [STAB_W-1:0]     stab_q, stab_d;
    logic                  armed_q, armed_d;

    // Frame assembly
    logic [NUM_DIGITS-1:0][3:0] nib_q, nib_d;
    logic [NUM_DIGITS-1:0]      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]      bad_q, bad_d;
    logic [NUM_DIGITS-1:0]      mask_q, mask_d;
    logic [TOUT_W-1:0]          tout_q, tout_d;

    // Registered outputs
    logic [DATA_W-1:0] data_q, data_d;
    logic              dv_q, dv_d;
    logic              err_q, err_d;
    logic              tpulse_q, tpulse_d;

    // Combinational helpers
    logic [NUM_DIGITS-1:0] sel_c;
    logic [7:0]            seg_c;
    logic [NUM_DIGITS+7:0] sample_c;
    sel_class_e            sel_class_c;
    logic                  match_c;
    logic                  accept_c;
    logic                  frame_done_c;
    logic                  timeout_c;
    logic [1:0]            digit_c;
    logic [3:0]            dec_nib;
    logic                  dec_ok;

    assign sel_c       = DRAIN_ACTIVE_LOW ? ~drains_s2_q : drains_s2_q;
    assign seg_c       = SEG_ACTIVE_LOW ? ~leds_s2_q : leds_s2_q;
    assign sample_c    = {sel_c, seg_c};
    assign sel_class_c = classify_sel(sel_c);
    assign digit_c     = onehot_index(sel_c);

    seg7_to_hex u_decode (
        .seg_i    (seg_c[SEG_G:SEG_A]),
        .nibble_o (dec_nib),
        .valid_o  (dec_ok)
    );

    // Stability counter: one accept per dwell, re-armed by any change or a non-valid select.
    always_comb begin
        match_c = (sel_class_c == SEL_VALID) && (sample_c == prev_q);
        stab_d  = '0;
        armed_d = 1'b1;
        if (match_c) begin
            stab_d  = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
            armed_d = armed_q;
        end
        accept_c = match_c && armed_q && (stab_d == STAB_ACCEPT);
        if (accept_c) begin
            armed_d = 1'b0;
        end
    end

    // Frame completion takes priority over a coincident timeout.
    always_comb begin
        frame_done_c = (mask_q == {NUM_DIGITS{1'b1}});
        timeout_c    = (mask_q != '0) && !frame_done_c && !accept_c && (tout_q == TOUT_LAST);

        nib_d    = nib_q;
        dp_d     = dp_q;
        bad_d    = bad_q;
        mask_d   = mask_q;
        data_d   = data_q;
        dv_d     = 1'b0;
        err_d    = err_q;
        tpulse_d = 1'b0;

        if (frame_done_c) begin
            data_d = {dp_q, nib_q};
            dv_d   = 1'b1;
            err_d  = |bad_q;
            mask_d = '0;
            bad_d  = '0;
        end else if (timeout_c) begin
            tpulse_d = 1'b1;
            mask_d   = '0;
            bad_d    = '0;
        end

        if (accept_c) begin
            nib_d[digit_c]  = dec_ok ? dec_nib : 4'h0;
            dp_d[digit_c]   = seg_c[SEG_DP];
            bad_d[digit_c]  = !dec_ok;
            mask_d[digit_c] = 1'b1;
        end

        if ((mask_q == '0) || accept_c || frame_done_c || timeout_c) begin
            tout_d = '0;
        end else begin
            tout_d = tout_q + 1'b1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            drains_s1_q <= '0;
            drains_s2_q <= '0;
            leds_s1_q   <= '0;
            leds_s2_q   <= '0;
            prev_q      <= '0;
            stab_q      <= '0;
            armed_q     <= 1'b1;
            nib_q       <= '0;
            dp_q        <= '0;
            bad_q       <= '0;
            mask_q      <= '0;
            tout_q      <= '0;
            data_q      <= '0;
            dv_q        <= 1'b0;
            err_q       <= 1'b0;
            tpulse_q    <= 1'b0;
        end else begin
            drains_s1_q <= i_Drains;
            drains_s2_q <= drains_s1_q;
            leds_s1_q   <= i_Leds;
            leds_s2_q   <= leds_s1_q;
            prev_q      <= sample_c;
            stab_q      <= stab_d;
            armed_q     <= armed_d;
            nib_q       <= nib_d;
            dp_q        <= dp_d;
            bad_q       <= bad_d;
            mask_q      <= mask_d;
            tout_q      <= tout_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            err_q       <= err_d;
            tpulse_q    <= tpulse_d;
        end
    end

    assign o_Data       = data_q;
    assign o_Data_DV    = dv_q;
    assign o_Frame_Err  = err_q;
    assign o_Timeout    = tpulse_q;
    assign o_Digit_Mask = mask_q;

endmodule

// File: tb/tb_seg8_scan_capture.sv
// Bench for seg8_scan_capture: directed scans plus random frames checked against
// a dwell-level model (a run of >= STABLE identical valid samples is one accept).
module tb_seg8_scan_capture;

    localparam int STABLE = 64;
    localparam int TOUT   = 3000;
    localparam logic [6:0] GLYPHS [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  drains = 4'hF;
    logic [7:0]  leds = 8'h00;
    logic [19:0] o_data;
    logic        o_dv, o_err, o_to;
    logic [3:0]  o_mask;

    always #5 clk = ~clk;

    seg8_scan_capture #(
        .STABLE_CYCLES    (STABLE),
        .TIMEOUT_CYCLES   (TOUT),
        .DRAIN_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW   (1'b0)
    ) dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_Drains     (drains),
        .i_Leds       (leds),
        .o_Data       (o_data),
        .o_Data_DV    (o_dv),
        .o_Frame_Err  (o_err),
        .o_Timeout    (o_to),
        .o_Digit_Mask (o_mask)
    );

    int checks = 0;
    int errors = 0;

    // Observed pulse counts
    int dv_cnt = 0;
    int to_cnt = 0;
    always @(negedge clk) begin
        if (o_dv) dv_cnt++;
        if (o_to) to_cnt++;
    end

    // Reference model state
    logic [11:0]     run_val = '0;
    int              run_len = 0;
    bit              run_acc = 1'b0;
    logic [3:0]      m_mask = '0;
    logic [3:0][3:0] m_nib = '0;
    logic [3:0]      m_dp = '0;
    logic [3:0]      m_bad = '0;
    logic [19:0]     m_data = '0;
    bit              m_err = 1'b0;
    int              m_dv = 0;
    int              m_to = 0;

    task automatic model_accept(input int k, input logic [7:0] l);
        bit found;
        logic [3:0] nib;
        found = 1'b0;
        nib = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (!found && GLYPHS[i] == l[6:0]) begin
                found = 1'b1;
                nib = 4'(i);
            end
        end
        m_nib[k]  = nib;
        m_dp[k]   = l[7];
        m_bad[k]  = !found;
        m_mask[k] = 1'b1;
        if (m_mask == 4'hF) begin
            m_data = {m_dp, m_nib};
            m_err  = |m_bad;
            m_dv++;
            m_mask = '0;
            m_bad  = '0;
        end
    endtask

    // Drive one value for n clocks (called aligned to a falling edge) and update the model.
    task automatic hold(input logic [3:0] d, input logic [7:0] l, input int n);
        logic [3:0] act;
        bit valid;
        drains = d;
        leds   = l;
        repeat (n) @(negedge clk);
        act   = ~d;
        valid = ($countones(act) == 1);
        if (valid && run_len > 0 && {act, l} == run_val) begin
            run_len += n;
        end else begin
            run_val = {act, l};
            run_len = valid ? n : 0;
            run_acc = 1'b0;
        end
        if (valid && !run_acc && run_len >= STABLE) begin
            run_acc = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (act[k]) model_accept(k, l);
            end
        end
    endtask

    task automatic idle(input int n);
        hold(4'hF, 8'h00, n);
        if (n >= TOUT && m_mask != '0) begin
            m_to++;
            m_mask = '0;
            m_bad  = '0;
        end
    endtask

    task automatic digit(input int k, input logic [7:0] l, input int n);
        hold(~(4'b0001 << k), l, n);
        hold(4'hF, 8'h00, 4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_data, o_dv, o_err, o_to, o_mask} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h dv=%b err=%b to=%b mask=%b, expected all 0",
                     o_data, o_dv, o_err, o_to, o_mask);
        end
        rst_n = 1'b1;
        idle(5);
        checks++;
        if (o_mask !== 4'h0 || dv_cnt !== 0) begin
            errors++;
            $display("FAIL reset_idle: got mask=%b dv_cnt=%0d, expected 0000 and 0", o_mask, dv_cnt);
        end
    endtask

    task automatic test_basic_scan();
        digit(0, 8'h3F, 100);
        digit(1, 8'h06, 100);
        digit(2, 8'h5B, 100);
        digit(3, 8'hCF, 100);
        $display("basic_scan: data=%h err=%b dv_cnt=%0d", o_data, o_err, dv_cnt);
        checks++;
        if (dv_cnt !== m_dv || m_dv !== 1) begin
            errors++;
            $display("FAIL basic_dv_count: got %0d, expected %0d", dv_cnt, m_dv);
        end
        checks++;
        if (o_data !== 20'h8_3210 || o_data !== m_data) begin
            errors++;
            $display("FAIL basic_data: got %h, expected %h", o_data, 20'h8_3210);
        end
        checks++;
        if (o_err !== 1'b0 || o_mask !== 4'h0) begin
            errors++;
            $display("FAIL basic_err_mask: got err=%b mask=%b, expected 0 and 0000", o_err, o_mask);
        end
    endtask

    task automatic test_short_dwell_timeout();
        digit(0, 8'h66, 100);
        digit(1, 8'h6D, 100);
        digit(2, 8'h7D, 10);
        digit(3, 8'h07, 100);
        $display("short_dwell: mask=%b dv_cnt=%0d", o_mask, dv_cnt);
        checks++;
        if (o_mask !== 4'b1011 || o_mask !== m_mask || dv_cnt !== m_dv) begin
            errors++;
            $display("FAIL short_dwell_mask: got mask=%b dv_cnt=%0d, expected %b and %0d",
                     o_mask, dv_cnt, m_mask, m_dv);
        end
        idle(TOUT + 300);
        $display("timeout: mask=%b to_cnt=%0d", o_mask, to_cnt);
        checks++;
        if (to_cnt !== m_to || m_to !== 1 || o_mask !== 4'h0) begin
            errors++;
            $display("FAIL timeout_pulse: got to_cnt=%0d mask=%b, expected %0d and 0000", to_cnt, o_mask, m_to);
        end
        checks++;
        if (o_data !== 20'h8_3210) begin
            errors++;
            $display("FAIL timeout_data_kept: got %h, expected %h", o_data, 20'h8_3210);
        end
    endtask

    task automatic test_bad_glyph();
        digit(0, 8'h7F, 100);
        digit(1, 8'h49, 100);
        digit(2, 8'h6F, 100);
        digit(3, 8'h77, 100);
        $display("bad_glyph: data=%h err=%b", o_data, o_err);
        checks++;
        if (dv_cnt !== m_dv || o_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_glyph_err: got dv_cnt=%0d err=%b, expected %0d and 1", dv_cnt, o_err, m_dv);
        end
        checks++;
        if (o_data !== m_data || o_data[7:4] !== 4'h0) begin
            errors++;
            $display("FAIL bad_glyph_data: got %h, expected %h", o_data, m_data);
        end
    endtask

    task automatic test_invalid_select();
        digit(0, 8'h3F, 100);
        digit(1, 8'h06, 100);
        hold(4'b1100, 8'h5B, 200);
        hold(4'hF, 8'h00, 4);
        checks++;
        if (o_mask !== 4'b0011 || o_mask !== m_mask) begin
            errors++;
            $display("FAIL invalid_select_mask: got %b, expected %b", o_mask, m_mask);
        end
        digit(2, 8'h5B, 100);
        digit(3, 8'h4F, 100);
        $display("invalid_select: data=%h dv_cnt=%0d", o_data, dv_cnt);
        checks++;
        if (dv_cnt !== m_dv || o_data !== 20'h0_3210 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL invalid_select_data: got %h err=%b dv_cnt=%0d, expected %h err=0 dv_cnt=%0d",
                     o_data, o_err, dv_cnt, 20'h0_3210, m_dv);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 6; i++) begin
            hold(4'hE, 8'h3F, 8);
            hold(4'hE, 8'h06, 8);
        end
        checks++;
        if (o_mask !== 4'h0) begin
            errors++;
            $display("FAIL bounce_no_accept: got mask=%b, expected 0000", o_mask);
        end
        hold(4'hE, 8'h06, 100);
        checks++;
        if (o_mask !== 4'b0001 || o_mask !== m_mask) begin
            errors++;
            $display("FAIL bounce_accept: got mask=%b, expected %b", o_mask, m_mask);
        end
        hold(4'hF, 8'h00, 4);
        digit(1, 8'h39, 100);
        digit(2, 8'h5E, 100);
        digit(3, 8'h71, 100);
        $display("bounce: data=%h dv_cnt=%0d", o_data, dv_cnt);
        checks++;
        if (o_data !== m_data || o_data[3:0] !== 4'h1 || dv_cnt !== m_dv) begin
            errors++;
            $display("FAIL bounce_data: got %h dv_cnt=%0d, expected %h dv_cnt=%0d", o_data, dv_cnt, m_data, m_dv);
        end
    endtask

    task automatic test_reset_mid_frame();
        digit(0, 8'h06, 100);
        digit(1, 8'h5B, 100);
        checks++;
        if (o_mask !== 4'b0011) begin
            errors++;
            $display("FAIL midreset_pre_mask: got %b, expected 0011", o_mask);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_data, o_dv, o_err, o_to, o_mask} !== 28'h0) begin
            errors++;
            $display("FAIL midreset_async: got data=%h dv=%b err=%b to=%b mask=%b, expected all 0",
                     o_data, o_dv, o_err, o_to, o_mask);
        end
        m_mask = '0;
        m_bad  = '0;
        m_data = '0;
        m_err  = 1'b0;
        run_len = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        digit(0, 8'h79, 100);
        digit(1, 8'h71, 100);
        digit(2, 8'h77, 100);
        digit(3, 8'h7C, 100);
        $display("reset_mid_frame: data=%h dv_cnt=%0d", o_data, dv_cnt);
        checks++;
        if (o_data !== 20'h0_BAFE || o_data !== m_data || dv_cnt !== m_dv) begin
            errors++;
            $display("FAIL midreset_rescan: got %h dv_cnt=%0d, expected %h dv_cnt=%0d",
                     o_data, dv_cnt, 20'h0_BAFE, m_dv);
        end
    endtask

    task automatic test_random_frames();
        int k, len, nh;
        logic [7:0] l;
        for (int f = 0; f < 8; f++) begin
            nh = $urandom_range(4, 7);
            for (int h = 0; h < nh; h++) begin
                k = $urandom_range(0, 3);
                if ($urandom_range(0, 5) == 0) l = 8'($urandom);
                else l = {1'($urandom), GLYPHS[$urandom_range(0, 15)]};
                if ($urandom_range(0, 4) == 0) len = $urandom_range(2, STABLE - 8);
                else len = $urandom_range(STABLE + 8, 120);
                hold(~(4'b0001 << k), l, len);
                hold(4'hF, 8'h00, $urandom_range(1, 12));
            end
            $display("random_frame %0d: data=%h err=%b mask=%b dv_cnt=%0d", f, o_data, o_err, o_mask, dv_cnt);
            checks++;
            if (dv_cnt !== m_dv || o_data !== m_data || o_err !== m_err) begin
                errors++;
                $display("FAIL random_frame_%0d: got data=%h err=%b dv_cnt=%0d, expected data=%h err=%b dv_cnt=%0d",
                         f, o_data, o_err, dv_cnt, m_data, m_err, m_dv);
            end
            checks++;
            if (o_mask !== m_mask || to_cnt !== m_to) begin
                errors++;
                $display("FAIL random_mask_%0d: got mask=%b to_cnt=%0d, expected mask=%b to_cnt=%0d",
                         f, o_mask, to_cnt, m_mask, m_to);
            end
            if (m_mask != '0) begin
                idle(TOUT + 300);
                checks++;
                if (to_cnt !== m_to || o_mask !== 4'h0) begin
                    errors++;
                    $display("FAIL random_timeout_%0d: got to_cnt=%0d mask=%b, expected %0d and 0000",
                             f, to_cnt, o_mask, m_to);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_scan();
        test_short_dwell_timeout();
        test_bad_glyph();
        test_invalid_select();
        test_bounce();
        test_reset_mid_frame();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
